// File: rtl/tpic_pkg.sv
// Shared constants for the TPIC readback checker: chain geometry, read map, status layout.
package tpic_pkg;

  localparam int unsigned TPIC_WIDTH  = 300;
  localparam int unsigned TPIC_CNT_W  = $clog2(TPIC_WIDTH + 1);
  localparam int unsigned TPIC_NBYTES = (TPIC_WIDTH + 7) / 8;

  localparam logic [7:0] ADDR_STATUS = 8'hFE;
  localparam logic [7:0] ADDR_ERRCNT = 8'hFF;

  localparam int unsigned STAT_ERR_BIT = 0;
  localparam int unsigned STAT_LEN_BIT = 1;
  localparam int unsigned STAT_PV_BIT  = 2;

endpackage

// File: rtl/tpic_readback_prio_enc.sv
// Combinational MSB-first priority encoder; the parent registers its outputs.
module msb_prio_enc #(
  parameter int unsigned WIDTH = 300,
  parameter int unsigned CNT_W = 9
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic             o_any,
  output logic [CNT_W-1:0] o_idx
);

  // Ascending scan so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i_vec[i]) begin
        o_any = 1'b1;
        o_idx = CNT_W'(i);
      end
    end
  end

endmodule

// File: rtl/tpic_readback.sv
// TPIC daisy-chain readback checker: captures tpic_miso during shifting and compares it
// against the frame latched at the previous RCK; exposes results on a byte read port.
module tpic_readback
  import tpic_pkg::*;
#(
  parameter int unsigned WIDTH  = TPIC_WIDTH,
  parameter int unsigned CNT_W  = $clog2(WIDTH + 1),
  parameter int unsigned NBYTES = (WIDTH + 7) / 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             byps,
  input  logic             sclk,
  input  logic             rck,
  input  logic             sin,
  input  logic [WIDTH-1:0] data,
  input  logic             clr_err,
  input  logic [7:0]       rd_addr,
  output logic [7:0]       rd_data,
  output logic             frame_done,
  output logic             err,
  output logic             len_err,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int unsigned      PADW     = NBYTES * 8;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  logic             r_sclk_d, r_rck_d;
  logic [WIDTH-1:0] r_shift, r_captured, r_shadow, r_diff;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_prev_valid;
  logic             r_v1, r_c1, r_v2, r_c2, r_any;
  logic [CNT_W-1:0] r_idx;

  logic             w_shift_en, w_latch, w_full, w_set_err, w_set_len, w_any;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] w_cnt_nxt, w_idx;
  logic [PADW-1:0]  w_cap_pad;
  logic [7:0]       w_status, w_rd_nxt;

  assign w_shift_en  = sclk & ~r_sclk_d & ~byps;
  assign w_latch     = rck & ~r_rck_d & ~byps;
  assign w_shift_nxt = w_shift_en ? {r_shift[WIDTH-2:0], sin} : r_shift;
  // A coincident shift is counted before the length check.
  assign w_cnt_nxt   = (w_shift_en && (r_bit_cnt != CNT_SAT)) ? r_bit_cnt + CNT_W'(1) : r_bit_cnt;
  assign w_full      = (w_cnt_nxt == CNT_FULL);
  assign w_set_len   = w_latch & ~w_full;
  assign w_set_err   = r_c2 & r_any & ~byps;
  assign w_cap_pad   = PADW'(r_captured);

  msb_prio_enc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_enc (
    .i_vec (r_diff),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  // Shift capture, bit counting and frame latching.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_d     <= 1'b0;
      r_rck_d      <= 1'b0;
      r_shift      <= '0;
      r_captured   <= '0;
      r_shadow     <= '0;
      r_bit_cnt    <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_sclk_d <= sclk;
      r_rck_d  <= rck;
      r_shift  <= w_shift_nxt;
      if (byps) begin
        r_bit_cnt    <= '0;
        r_prev_valid <= 1'b0;
      end else if (w_latch) begin
        r_bit_cnt <= '0;
        if (w_full) begin
          r_captured   <= w_shift_nxt;
          r_shadow     <= data;
          r_prev_valid <= 1'b1;
        end else begin
          r_prev_valid <= 1'b0;
        end
      end else begin
        r_bit_cnt <= w_cnt_nxt;
      end
    end
  end

  // Compare pipeline; diff is taken against the shadow before it reloads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_diff <= '0;
      r_v1   <= 1'b0;
      r_c1   <= 1'b0;
      r_v2   <= 1'b0;
      r_c2   <= 1'b0;
      r_any  <= 1'b0;
      r_idx  <= '0;
    end else begin
      if (w_latch) r_diff <= w_shift_nxt ^ r_shadow;
      r_v1  <= w_latch;
      r_c1  <= w_latch & w_full & r_prev_valid;
      r_v2  <= r_v1 & ~byps;
      r_c2  <= r_c1 & ~byps;
      r_any <= w_any;
      r_idx <= w_idx;
    end
  end

  // Sticky status; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done    <= 1'b0;
      err           <= 1'b0;
      len_err       <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      frame_done <= r_v2 & ~byps;
      if (w_set_err) begin
        err           <= 1'b1;
        err_cnt       <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
        first_err_idx <= r_idx;
      end else if (clr_err) begin
        err           <= 1'b0;
        err_cnt       <= '0;
        first_err_idx <= '0;
      end
      if (w_set_len)    len_err <= 1'b1;
      else if (clr_err) len_err <= 1'b0;
    end
  end

  always_comb begin
    w_status               = '0;
    w_status[STAT_ERR_BIT] = err;
    w_status[STAT_LEN_BIT] = len_err;
    w_status[STAT_PV_BIT]  = r_prev_valid;
    w_rd_nxt               = 8'h00;
    if (rd_addr == ADDR_STATUS) begin
      w_rd_nxt = w_status;
    end else if (rd_addr == ADDR_ERRCNT) begin
      w_rd_nxt = err_cnt;
    end else begin
      for (int k = 0; k < int'(NBYTES); k++) begin
        if (rd_addr == 8'(k)) w_rd_nxt = w_cap_pad[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= w_rd_nxt;
  end

endmodule

// File: tb/tb_tpic_readback.sv
// Directed bench for tpic_readback: loops sin from a model of the previous frame's chain.
module tb_tpic_readback;
  import tpic_pkg::*;

  localparam int W  = 300;
  localparam int CW = 9;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset_n, byps, sclk, rck, sin, clr_err;
  logic [W-1:0]  data;
  logic [7:0]    rd_addr, rd_data, err_cnt;
  logic          frame_done, err, len_err;
  logic [CW-1:0] first_err_idx;

  logic          s_sclk, s_rck, s_sin, s_clr, s_fd, s_err, s_len;
  logic [SW-1:0] s_data;
  logic [7:0]    s_rd_addr, s_rd_data, s_err_cnt;
  logic [3:0]    s_idx;

  logic [W-1:0]  chain;
  logic [W-1:0]  pat;
  logic [303:0]  pat_wide;
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          seen_fd;

  tpic_readback u_dut (
    .clk(clk), .reset_n(reset_n), .byps(byps), .sclk(sclk), .rck(rck), .sin(sin),
    .data(data), .clr_err(clr_err), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_done(frame_done), .err(err), .len_err(len_err), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx)
  );

  tpic_readback #(.WIDTH(SW), .CNT_W(4), .NBYTES(1)) u_small (
    .clk(clk), .reset_n(reset_n), .byps(1'b0), .sclk(s_sclk), .rck(s_rck), .sin(s_sin),
    .data(s_data), .clr_err(s_clr), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .frame_done(s_fd), .err(s_err), .len_err(s_len), .err_cnt(s_err_cnt),
    .first_err_idx(s_idx)
  );

  always #20 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  // Chain returns the previous frame MSB-first; 'stuck' forces that captured bit to 1.
  task automatic shift_bits(input int n, input int stuck);
    for (int j = 0; j < n; j++) begin
      sin  = ((W - 1 - j) == stuck) ? 1'b1 : chain[W-1-j];
      sclk = 1'b1;
      tick();
      sclk = 1'b0;
      tick();
    end
  endtask

  task automatic send_frame(input string tag, input logic [W-1:0] d, input int n,
                            input int stuck, input logic clr_at_done);
    data = d;
    shift_bits(n, stuck);
    rck = 1'b1;
    tick();
    rck = 1'b0;
    tick();
    chk({tag, "_fd_early"}, 32'(frame_done), 32'd0);
    clr_err = clr_at_done;
    tick();
    clr_err = 1'b0;
    chk({tag, "_fd"}, 32'(frame_done), 32'd1);
    if (n == W) chain = d;
  endtask

  initial begin
    reset_n = 1'b0; byps = 1'b0; sclk = 1'b0; rck = 1'b0; sin = 1'b0; clr_err = 1'b0;
    data = '0; rd_addr = 8'h00; chain = '0;
    s_sclk = 1'b0; s_rck = 1'b0; s_sin = 1'b0; s_clr = 1'b0; s_data = '0; s_rd_addr = 8'hFF;
    pat_wide = {38{8'hA5}};
    pat = pat_wide[W-1:0];
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_len", 32'(len_err), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    chk("rst_idx", 32'(first_err_idx), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);

    // Two clean frames: first only arms, second compares.
    send_frame("f1", '0, W, -1, 1'b0);
    chk("f1_err", 32'(err), 32'd0);
    send_frame("f2", '0, W, -1, 1'b0);
    chk("f2_err", 32'(err), 32'd0);
    rd_chk("f2_stat", ADDR_STATUS, 8'h04);

    // Bit 17 stuck high.
    send_frame("f3", '0, W, 17, 1'b0);
    chk("f3_err", 32'(err), 32'd1);
    chk("f3_idx", 32'(first_err_idx), 32'd17);
    chk("f3_cnt", 32'(err_cnt), 32'd1);
    rd_chk("f3_rdcnt", ADDR_ERRCNT, 8'h01);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_cnt", 32'(err_cnt), 32'd0);
    chk("clr_idx", 32'(first_err_idx), 32'd0);

    // 0xA5 pattern latched, then looped back.
    send_frame("f4", pat, W, -1, 1'b0);
    chk("f4_err", 32'(err), 32'd0);
    send_frame("f5", '0, W, -1, 1'b0);
    chk("f5_err", 32'(err), 32'd0);
    rd_chk("rd_b0", 8'd0, 8'hA5);
    rd_chk("rd_b1", 8'd1, 8'hA5);
    rd_chk("rd_b37", 8'd37, 8'h05);
    rd_chk("rd_x50", 8'h50, 8'h00);

    // Short frame: length error, next frame only re-arms.
    send_frame("f6", '0, W - 1, -1, 1'b0);
    chk("f6_len", 32'(len_err), 32'd1);
    rd_chk("f6_stat", ADDR_STATUS, 8'h02);
    send_frame("f7", '0, W, 17, 1'b0);
    chk("f7_nocmp", 32'(err), 32'd0);
    send_frame("f8", '0, W, -1, 1'b0);
    chk("f8_err", 32'(err), 32'd0);
    rd_chk("f8_stat", ADDR_STATUS, 8'h06);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    rd_chk("clr_stat", ADDR_STATUS, 8'h04);

    // Bypass right after RCK discards the in-flight compare.
    data = '0;
    shift_bits(W, 17);
    rck = 1'b1;
    tick();
    rck = 1'b0;
    byps = 1'b1;
    seen_fd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sclk = i[0];
      tick();
      seen_fd = seen_fd | frame_done;
    end
    sclk = 1'b0;
    chk("byp_nofd", 32'(seen_fd), 32'd0);
    chk("byp_err", 32'(err), 32'd0);
    rd_chk("byp_stat", ADDR_STATUS, 8'h00);
    byps = 1'b0;
    tick();

    // Bypass mid-shift clears the bit counter.
    shift_bits(150, -1);
    byps = 1'b1;
    tick(); tick();
    byps = 1'b0;
    tick();
    send_frame("f10", '0, W, 17, 1'b0);
    chk("f10_len", 32'(len_err), 32'd0);
    chk("f10_nocmp", 32'(err), 32'd0);
    send_frame("f11", '0, W, 5, 1'b0);
    chk("f11_err", 32'(err), 32'd1);
    chk("f11_idx", 32'(first_err_idx), 32'd5);
    rd_chk("f11_stat", ADDR_STATUS, 8'h05);

    // clr_err coincident with a mismatch result: the set wins.
    send_frame("f12", '0, W, 5, 1'b1);
    chk("f12_err", 32'(err), 32'd1);
    chk("f12_cnt", 32'(err_cnt), 32'd2);
    chk("f12_idx", 32'(first_err_idx), 32'd5);

    // Mid-operation reset.
    reset_n = 1'b0;
    #1;
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_cnt", 32'(err_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Saturation on the 8-bit instance: every frame after the first mismatches.
    for (int f = 0; f < 301; f++) begin
      for (int b = 0; b < SW; b++) begin
        s_sin  = 1'b1;
        s_sclk = 1'b1;
        tick();
        s_sclk = 1'b0;
        tick();
      end
      s_rck = 1'b1;
      tick();
      s_rck = 1'b0;
      tick(); tick(); tick();
      if (f == 2) chk("sat_cnt3", 32'(s_err_cnt), 32'd2);
    end
    tick();
    chk("sat_err", 32'(s_err), 32'd1);
    chk("sat_cnt", 32'(s_err_cnt), 32'd255);
    chk("sat_idx", 32'(s_idx), 32'd7);
    chk("sat_rd", 32'(s_rd_data), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
